// File: rtl/burst_ram_pkg.sv
// ----------------------------------------------------------------------------
// burst_ram_pkg
// Shared definitions for the single-line write-back cache that sits in front
// of BurstRAM.
//  - CMD_READ / CMD_WRITE : values driven on the BurstRAM br_cmd pin
//  - cache_state_t        : one-hot cache controller states
//  - WORD_BYTE_BITS       : byte-in-word offset bits of a CPU address
//  - geometry helpers     : beat index, 32-bit lane index and tag widths,
//                           derived from the cache parameters
// ----------------------------------------------------------------------------
package burst_ram_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int WORD_BYTE_BITS = 2;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      WB    = 4'b0010,
      FILL  = 4'b0100,
      SERVE = 4'b1000
   } cache_state_t;

   // Bits needed to pick one beat of a line.
   function automatic int beat_idx_width(input int burst_count);
      return $clog2(burst_count);
   endfunction

   // Bits needed to pick one 32-bit lane of a beat (0 for 32-bit beats).
   function automatic int lane_idx_width(input int data_bitwidth);
      return $clog2(data_bitwidth / 32);
   endfunction

   // The tag is whatever is left of the RAM word address above the beat index.
   function automatic int tag_width(input int ram_depth_bitwidth, input int burst_count);
      return ram_depth_bitwidth - $clog2(burst_count);
   endfunction

endpackage

// File: rtl/burst_line_store.sv
// ----------------------------------------------------------------------------
// burst_line_store
// Data storage for the cache line: BURST_COUNT beats of DATA_BITWIDTH bits.
// Ports:
//  clk        : clock
//  st_en      : byte-enabled 32-bit store into one lane of one beat
//  st_beat    : beat addressed by the store
//  st_lane    : 32-bit lane within that beat
//  st_wstrb   : byte enables of the store
//  st_wdata   : store data
//  fill_en    : whole-beat write from a refill burst (wins over st_en)
//  fill_beat  : beat written by the refill
//  fill_data  : refill beat data
//  rd_beat    : beat presented on rd_data
//  rd_data    : combinational read of beat rd_beat
// The array is deliberately not reset; validity is tracked by the controller.
// ----------------------------------------------------------------------------
module burst_line_store
   import burst_ram_pkg::*;
#(
   parameter int BURST_COUNT   = 4,
   parameter int DATA_BITWIDTH = 64
) (
   input  logic                                     clk,
   input  logic                                     st_en,
   input  logic [beat_idx_width(BURST_COUNT)-1:0]   st_beat,
   input  logic [((lane_idx_width(DATA_BITWIDTH) > 0) ? lane_idx_width(DATA_BITWIDTH) : 1)-1:0] st_lane,
   input  logic [3:0]                               st_wstrb,
   input  logic [31:0]                              st_wdata,
   input  logic                                     fill_en,
   input  logic [beat_idx_width(BURST_COUNT)-1:0]   fill_beat,
   input  logic [DATA_BITWIDTH-1:0]                 fill_data,
   input  logic [beat_idx_width(BURST_COUNT)-1:0]   rd_beat,
   output logic [DATA_BITWIDTH-1:0]                 rd_data
);

   logic [DATA_BITWIDTH-1:0] line_mem [BURST_COUNT];

   // Refill beats replace a whole beat; CPU stores merge only their enabled
   // bytes into the addressed 32-bit lane. The controller never requests both
   // in the same cycle, the priority only keeps the write port unambiguous.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         line_mem[fill_beat] <= fill_data;
      end else if (st_en) begin
         for (int b = 0; b < 4; b++) begin
            if (st_wstrb[b]) begin
               line_mem[st_beat][int'(st_lane) * 32 + b * 8 +: 8] <= st_wdata[b * 8 +: 8];
            end
         end
      end
   end

   assign rd_data = line_mem[rd_beat];

endmodule

// File: rtl/burst_line_cache.sv
// ----------------------------------------------------------------------------
// burst_line_cache
// Single-line write-back cache between a 32-bit CPU load/store port and the
// BurstRAM command interface. Hits answer one cycle after acceptance; a miss
// writes the old line back when dirty, then refills with a read burst.
// Ports:
//  clk, rst          : clock, synchronous active-high reset
//  req_valid/ready   : CPU request handshake (ready only in IDLE)
//  req_we            : 0 load, 1 store
//  req_addr          : byte address, bits [1:0] ignored
//  req_wstrb/wdata   : store byte enables and data
//  resp_valid        : one-cycle response pulse for every request
//  resp_rdata        : load data, 0 for stores
//  br_cmd/br_cmd_en  : BurstRAM command and one-cycle strobe
//  br_addr           : line base word address of the burst
//  br_wr_data        : write beat, beat 0 with the strobe then 1..N-1
//  br_data_mask      : tied to 0 (all bytes written)
//  br_rd_data/valid  : read beats returned by BurstRAM
//  br_busy           : BurstRAM cannot take a command
// ----------------------------------------------------------------------------
module burst_line_cache
   import burst_ram_pkg::*;
#(
   parameter int RAM_DEPTH_BITWIDTH = 4,
   parameter int BURST_COUNT        = 4,
   parameter int DATA_BITWIDTH      = 64,
   parameter int ADDR_BITWIDTH      = RAM_DEPTH_BITWIDTH + $clog2(DATA_BITWIDTH / 8)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic                            req_we,
   input  logic [ADDR_BITWIDTH-1:0]        req_addr,
   input  logic [3:0]                      req_wstrb,
   input  logic [31:0]                     req_wdata,
   output logic                            resp_valid,
   output logic [31:0]                     resp_rdata,
   output logic                            br_cmd,
   output logic                            br_cmd_en,
   output logic [RAM_DEPTH_BITWIDTH-1:0]   br_addr,
   output logic [DATA_BITWIDTH-1:0]        br_wr_data,
   output logic [DATA_BITWIDTH/8-1:0]      br_data_mask,
   input  logic [DATA_BITWIDTH-1:0]        br_rd_data,
   input  logic                            br_rd_data_valid,
   input  logic                            br_busy
);

   localparam int BEAT_W    = beat_idx_width(BURST_COUNT);
   localparam int LANE_BITS = lane_idx_width(DATA_BITWIDTH);
   localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
   localparam int TAG_W     = tag_width(RAM_DEPTH_BITWIDTH, BURST_COUNT);
   localparam int BEAT_LSB  = WORD_BYTE_BITS + LANE_BITS;
   localparam int TAG_LSB   = BEAT_LSB + BEAT_W;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

   cache_state_t        state;
   logic                line_valid;
   logic                dirty;
   logic [TAG_W-1:0]    line_tag;
   logic                cmd_issued;
   logic [BEAT_W-1:0]   beat_cnt;

   logic                lat_we;
   logic [TAG_W-1:0]    lat_tag;
   logic [BEAT_W-1:0]   lat_beat;
   logic [LANE_W-1:0]   lat_lane;
   logic [3:0]          lat_wstrb;
   logic [31:0]         lat_wdata;

   logic [TAG_W-1:0]    req_tag;
   logic [BEAT_W-1:0]   req_beat;
   logic [LANE_W-1:0]   req_lane;
   logic                hit;
   logic                cmd_ok;
   logic                unused_addr_bits;

   logic                st_en;
   logic [BEAT_W-1:0]   st_beat;
   logic [LANE_W-1:0]   st_lane;
   logic [3:0]          st_wstrb;
   logic [31:0]         st_wdata;
   logic                fill_en;
   logic [BEAT_W-1:0]   rd_beat;
   logic [LANE_W-1:0]   rd_lane;
   logic [DATA_BITWIDTH-1:0] rd_data;
   logic [31:0]         rd_word;

   // Byte address split: [1:0] byte in word (ignored), then 32-bit lane,
   // then beat within the line, then tag.
   assign req_tag  = req_addr[ADDR_BITWIDTH-1:TAG_LSB];
   assign req_beat = req_addr[TAG_LSB-1:BEAT_LSB];
   assign unused_addr_bits = ^req_addr[WORD_BYTE_BITS-1:0];

   if (LANE_BITS > 0) begin : g_lane
      assign req_lane = req_addr[BEAT_LSB-1:WORD_BYTE_BITS];
   end else begin : g_no_lane
      assign req_lane = '0;
   end

   assign hit          = line_valid && (req_tag == line_tag);
   assign req_ready    = (state == IDLE);
   assign br_data_mask = '0;

   // A command may go out only when the RAM is idle and no strobe is being
   // driven right now, so two strobes can never land on adjacent cycles.
   assign cmd_ok = !br_busy && !br_cmd_en;

   // Line read port: the write-back walks the beat counter, SERVE replays the
   // latched access, and IDLE looks at the incoming request for 1-cycle hits.
   always_comb begin
      rd_beat = req_beat;
      rd_lane = req_lane;
      case (state)
         WB: begin
            rd_beat = beat_cnt;
         end
         SERVE: begin
            rd_beat = lat_beat;
            rd_lane = lat_lane;
         end
         default: begin
         end
      endcase
      rd_word = rd_data[int'(rd_lane) * 32 +: 32];
   end

   // Line write ports: CPU stores on an IDLE hit or from the latched request
   // in SERVE; refill beats only while our own read burst is outstanding, so
   // stray read beats are dropped.
   always_comb begin
      st_en    = 1'b0;
      st_beat  = req_beat;
      st_lane  = req_lane;
      st_wstrb = req_wstrb;
      st_wdata = req_wdata;
      if (!rst && state == IDLE && req_valid && hit && req_we) begin
         st_en = 1'b1;
      end
      if (!rst && state == SERVE && lat_we) begin
         st_en    = 1'b1;
         st_beat  = lat_beat;
         st_lane  = lat_lane;
         st_wstrb = lat_wstrb;
         st_wdata = lat_wdata;
      end
      fill_en = !rst && (state == FILL) && cmd_issued && br_rd_data_valid;
   end

   burst_line_store #(
      .BURST_COUNT   (BURST_COUNT),
      .DATA_BITWIDTH (DATA_BITWIDTH)
   ) u_store (
      .clk       (clk),
      .st_en     (st_en),
      .st_beat   (st_beat),
      .st_lane   (st_lane),
      .st_wstrb  (st_wstrb),
      .st_wdata  (st_wdata),
      .fill_en   (fill_en),
      .fill_beat (beat_cnt),
      .fill_data (br_rd_data),
      .rd_beat   (rd_beat),
      .rd_data   (rd_data)
   );

   // Controller: hits are answered straight from IDLE; a miss latches the
   // request, optionally writes the dirty line back (strobe with beat 0, then
   // beats 1..N-1 on consecutive cycles), refills via a read burst and finally
   // replays the latched access in SERVE. All BurstRAM outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         line_valid <= 1'b0;
         dirty      <= 1'b0;
         line_tag   <= '0;
         cmd_issued <= 1'b0;
         beat_cnt   <= '0;
         lat_we     <= 1'b0;
         lat_tag    <= '0;
         lat_beat   <= '0;
         lat_lane   <= '0;
         lat_wstrb  <= '0;
         lat_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         br_cmd_en  <= 1'b0;
         br_cmd     <= CMD_READ;
         br_addr    <= '0;
         br_wr_data <= '0;
      end else begin
         resp_valid <= 1'b0;
         br_cmd_en  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (hit) begin
                     resp_valid <= 1'b1;
                     resp_rdata <= req_we ? 32'h0 : rd_word;
                     if (req_we && (req_wstrb != 4'b0000)) begin
                        dirty <= 1'b1;
                     end
                  end else begin
                     lat_we     <= req_we;
                     lat_tag    <= req_tag;
                     lat_beat   <= req_beat;
                     lat_lane   <= req_lane;
                     lat_wstrb  <= req_wstrb;
                     lat_wdata  <= req_wdata;
                     beat_cnt   <= '0;
                     cmd_issued <= 1'b0;
                     state      <= (line_valid && dirty) ? WB : FILL;
                  end
               end
            end
            WB: begin
               if (!cmd_issued) begin
                  if (cmd_ok) begin
                     br_cmd_en  <= 1'b1;
                     br_cmd     <= CMD_WRITE;
                     br_addr    <= {line_tag, {BEAT_W{1'b0}}};
                     br_wr_data <= rd_data;
                     beat_cnt   <= BEAT_W'(1);
                     cmd_issued <= 1'b1;
                  end
               end else begin
                  br_wr_data <= rd_data;
                  beat_cnt   <= beat_cnt + BEAT_W'(1);
                  if (beat_cnt == LAST_BEAT) begin
                     dirty      <= 1'b0;
                     cmd_issued <= 1'b0;
                     state      <= FILL;
                  end
               end
            end
            FILL: begin
               if (!cmd_issued) begin
                  if (cmd_ok) begin
                     br_cmd_en  <= 1'b1;
                     br_cmd     <= CMD_READ;
                     br_addr    <= {lat_tag, {BEAT_W{1'b0}}};
                     beat_cnt   <= '0;
                     cmd_issued <= 1'b1;
                  end
               end else if (br_rd_data_valid) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  if (beat_cnt == LAST_BEAT) begin
                     line_tag   <= lat_tag;
                     line_valid <= 1'b1;
                     cmd_issued <= 1'b0;
                     state      <= SERVE;
                  end
               end
            end
            SERVE: begin
               resp_valid <= 1'b1;
               resp_rdata <= lat_we ? 32'h0 : rd_word;
               if (lat_we && (lat_wstrb != 4'b0000)) begin
                  dirty <= 1'b1;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_burst_line_cache.sv
// ----------------------------------------------------------------------------
// tb_burst_line_cache
// Drives directed CPU requests into burst_line_cache with a small BurstRAM
// model on the other side. Expected responses and BurstRAM commands are queued
// when stimulus is issued; a monitor on the falling edge pops and compares
// whenever the cache presents a response or a command strobe.
// ----------------------------------------------------------------------------
module tb_burst_line_cache;

   localparam int RAM_DEPTH_BITWIDTH = 4;
   localparam int BURST_COUNT        = 4;
   localparam int DATA_BITWIDTH      = 64;
   localparam int ADDR_BITWIDTH      = 7;
   localparam int READ_DELAY         = 3;
   localparam int RAM_WORDS          = 16;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } resp_exp_t;

   typedef struct {
      logic        cmd;
      logic [3:0]  addr;
      logic [63:0] beat0;
   } cmd_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [6:0]  req_addr = '0;
   logic [3:0]  req_wstrb = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        br_cmd;
   logic        br_cmd_en;
   logic [3:0]  br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;
   logic [63:0] br_rd_data = '0;
   logic        br_rd_data_valid = 1'b0;
   logic        br_busy;

   int          checks_total = 0;
   int          checks_passed = 0;
   int          cyc = 0;
   int          resp_count = 0;
   logic        prev_cmd_en = 1'b0;
   resp_exp_t   resp_q[$];
   cmd_exp_t    cmd_q[$];

   logic [63:0] ram [RAM_WORDS];
   logic        mem_init_done = 1'b0;
   logic        inject_stray = 1'b0;
   int          wr_left = 0;
   int          wr_pos = 0;
   int          rd_wait = 0;
   int          rd_left = 0;
   int          rd_pos = 0;
   logic [3:0]  wr_base = '0;
   logic [3:0]  rd_base = '0;

   burst_line_cache #(
      .RAM_DEPTH_BITWIDTH (RAM_DEPTH_BITWIDTH),
      .BURST_COUNT        (BURST_COUNT),
      .DATA_BITWIDTH      (DATA_BITWIDTH),
      .ADDR_BITWIDTH      (ADDR_BITWIDTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_addr         (req_addr),
      .req_wstrb        (req_wstrb),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_rdata       (resp_rdata),
      .br_cmd           (br_cmd),
      .br_cmd_en        (br_cmd_en),
      .br_addr          (br_addr),
      .br_wr_data       (br_wr_data),
      .br_data_mask     (br_data_mask),
      .br_rd_data       (br_rd_data),
      .br_rd_data_valid (br_rd_data_valid),
      .br_busy          (br_busy)
   );

   // 10 ns clock and a cycle counter used for response latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // BurstRAM model: a write strobe carries beat 0, the next beats follow on
   // consecutive cycles; a read strobe returns the line READ_DELAY cycles
   // later. Busy covers both. Contents are loaded once, on the first reset.
   assign br_busy = (wr_left != 0) || (rd_wait != 0) || (rd_left != 0);

   always @(posedge clk) begin
      br_rd_data_valid <= 1'b0;
      if (rst) begin
         wr_left <= 0;
         wr_pos  <= 0;
         rd_wait <= 0;
         rd_left <= 0;
         rd_pos  <= 0;
         if (!mem_init_done) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
               ram[i] <= (i == 0) ? 64'h0123456789ABCDEF
                                  : {16'hC0DE, 8'(i), 8'h00, 16'hBEEF, 8'(i), 8'h11};
            end
            mem_init_done <= 1'b1;
         end
      end else begin
         if (wr_left != 0) begin
            ram[wr_base + 4'(wr_pos)] <= br_wr_data;
            wr_pos  <= wr_pos + 1;
            wr_left <= wr_left - 1;
         end
         if (rd_wait != 0) begin
            rd_wait <= rd_wait - 1;
         end else if (rd_left != 0) begin
            br_rd_data_valid <= 1'b1;
            br_rd_data       <= ram[rd_base + 4'(rd_pos)];
            rd_pos  <= rd_pos + 1;
            rd_left <= rd_left - 1;
         end
         if (br_cmd_en) begin
            if (br_cmd) begin
               ram[br_addr] <= br_wr_data;
               wr_base <= br_addr;
               wr_pos  <= 1;
               wr_left <= BURST_COUNT - 1;
            end else begin
               rd_base <= br_addr;
               rd_pos  <= 0;
               rd_wait <= READ_DELAY;
               rd_left <= BURST_COUNT;
            end
         end
         if (inject_stray) begin
            br_rd_data_valid <= 1'b1;
            br_rd_data       <= 64'hDEADBEEFDEADBEEF;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: compares every response and every command strobe against the
   // front of the matching expectation queue, and checks strobe legality.
   always @(negedge clk) begin
      if (resp_valid) begin
         resp_count++;
         if (resp_q.size() == 0) begin
            checkOutput("unexpected_resp", 64'h1, 64'h0);
         end else begin
            resp_exp_t e;
            e = resp_q.pop_front();
            checkOutput("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
            if (e.lat >= 0) begin
               checkOutput("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
            end
         end
      end
      if (br_cmd_en) begin
         checkOutput("cmd_while_busy", 64'(br_busy), 64'h0);
         checkOutput("cmd_back_to_back", 64'(prev_cmd_en), 64'h0);
         if (cmd_q.size() == 0) begin
            checkOutput("unexpected_cmd", 64'h1, 64'h0);
         end else begin
            cmd_exp_t c;
            c = cmd_q.pop_front();
            checkOutput("cmd_kind", 64'(br_cmd), 64'(c.cmd));
            checkOutput("cmd_addr", 64'(br_addr), 64'(c.addr));
            if (c.cmd) begin
               checkOutput("wb_beat0", br_wr_data, c.beat0);
            end
         end
      end
      prev_cmd_en = br_cmd_en;
   end

   // Drive one request from a falling edge, queue its expected response and
   // return on the falling edge after it was accepted. exp_lat < 0 skips the
   // latency check (misses).
   task automatic applyStimulus(input logic we, input logic [6:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_lat);
      int waited;
      waited    = 0;
      req_we    = we;
      req_addr  = addr;
      req_wstrb = wstrb;
      req_wdata = wdata;
      req_valid = 1'b1;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         checkOutput("req_ready_timeout", 64'h0, 64'h1);
         return;
      end
      resp_q.push_back('{exp_rdata, exp_lat, cyc});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic pushCmd(input logic cmd, input logic [3:0] addr, input logic [63:0] beat0);
      cmd_q.push_back('{cmd, addr, beat0});
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((resp_q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (resp_q.size() != 0) begin
         checkOutput("drain_timeout", 64'(resp_q.size()), 64'h0);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int resp_before;

      // Reset state.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_resp_valid", 64'(resp_valid), 64'h0);
      checkOutput("reset_resp_rdata", 64'(resp_rdata), 64'h0);
      checkOutput("reset_cmd_en", 64'(br_cmd_en), 64'h0);
      checkOutput("reset_cmd", 64'(br_cmd), 64'h0);
      checkOutput("reset_br_addr", 64'(br_addr), 64'h0);
      checkOutput("reset_wr_data", br_wr_data, 64'h0);
      checkOutput("data_mask", 64'(br_data_mask), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_req_ready", 64'(req_ready), 64'h1);

      // Cold load: one read burst at base 0, no write-back.
      pushCmd(1'b0, 4'd0, 64'h0);
      applyStimulus(1'b0, 7'h00, 4'h0, 32'h0, 32'h89ABCDEF, -1);

      // Back-to-back hits on line 0.
      applyStimulus(1'b0, 7'h04, 4'h0, 32'h0, 32'h01234567, 1);
      applyStimulus(1'b0, 7'h08, 4'h0, 32'h0, 32'hBEEF0111, 1);
      applyStimulus(1'b0, 7'h1C, 4'h0, 32'h0, 32'hC0DE0300, 1);

      // Store merges, then read back.
      applyStimulus(1'b1, 7'h00, 4'b0001, 32'h000000AA, 32'h0, 1);
      applyStimulus(1'b0, 7'h00, 4'h0, 32'h0, 32'h89ABCDAA, 1);
      applyStimulus(1'b1, 7'h0C, 4'b1100, 32'h55667788, 32'h0, 1);
      applyStimulus(1'b0, 7'h0C, 4'h0, 32'h0, 32'h55660100, 1);

      // Dirty eviction: write-back of line 0, then refill of line 1.
      pushCmd(1'b1, 4'd0, 64'h0123456789ABCDAA);
      pushCmd(1'b0, 4'd4, 64'h0);
      applyStimulus(1'b0, 7'h20, 4'h0, 32'h0, 32'hBEEF0411, -1);
      waitDrain();
      checkOutput("ram_word0", ram[0], 64'h0123456789ABCDAA);
      checkOutput("ram_word1", ram[1], {32'h55660100, 32'hBEEF0111});
      checkOutput("ram_word2", ram[2], 64'hC0DE0200BEEF0211);
      checkOutput("ram_word3", ram[3], 64'hC0DE0300BEEF0311);

      // Hits on line 1, including a store with no byte enables.
      applyStimulus(1'b0, 7'h2C, 4'h0, 32'h0, 32'hC0DE0500, 1);
      applyStimulus(1'b1, 7'h20, 4'b0000, 32'hFFFFFFFF, 32'h0, 1);
      applyStimulus(1'b0, 7'h20, 4'h0, 32'h0, 32'hBEEF0411, 1);

      // Clean eviction: read burst only.
      pushCmd(1'b0, 4'd8, 64'h0);
      applyStimulus(1'b0, 7'h40, 4'h0, 32'h0, 32'hBEEF0811, -1);
      waitDrain();

      // Read beats arriving while idle must not touch the line.
      inject_stray = 1'b1;
      repeat (2) @(negedge clk);
      inject_stray = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 7'h40, 4'h0, 32'h0, 32'hBEEF0811, 1);
      applyStimulus(1'b0, 7'h44, 4'h0, 32'h0, 32'hC0DE0800, 1);
      waitDrain();

      // Reset during the read delay of a refill.
      pushCmd(1'b0, 4'd12, 64'h0);
      req_we    = 1'b0;
      req_addr  = 7'h60;
      req_wstrb = 4'h0;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!br_cmd_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midfill_cmd_seen", 64'(br_cmd_en), 64'h1);
      @(negedge clk);
      resp_before = resp_count;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_req_ready", 64'(req_ready), 64'h1);
      repeat (10) @(negedge clk);
      checkOutput("post_reset_no_resp", 64'(resp_count - resp_before), 64'h0);
      checkOutput("post_reset_cmd_q", 64'(cmd_q.size()), 64'h0);

      // Line was invalidated: the old line misses, then the same address again.
      pushCmd(1'b0, 4'd8, 64'h0);
      applyStimulus(1'b0, 7'h44, 4'h0, 32'h0, 32'hC0DE0800, -1);
      pushCmd(1'b0, 4'd12, 64'h0);
      applyStimulus(1'b0, 7'h60, 4'h0, 32'h0, 32'hBEEF0C11, -1);
      waitDrain();

      checkOutput("resp_queue_empty", 64'(resp_q.size()), 64'h0);
      checkOutput("cmd_queue_empty", 64'(cmd_q.size()), 64'h0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/burst_line_cache.md
Name: burst_line_cache

Overview:
- Single-line write-back cache between a 32-bit CPU load/store port and the BurstRAM command interface.
- Holds one line of BURST_COUNT x DATA_BITWIDTH bits plus tag, valid and dirty state.
- Hits complete in 1 cycle. A miss evicts the line with a burst write if it is dirty, then refills it with a burst read.
- Sits directly upstream of BurstRAM and is the only master on its cmd/data pins.

Parameters:
- RAM_DEPTH_BITWIDTH, 4: RAM address width, in DATA_BITWIDTH-bit words. Matches the BurstRAM DEPTH_BITWIDTH.
- BURST_COUNT, 4: beats per burst, which is also beats per line. Power of 2, at least 2.
- DATA_BITWIDTH, 64: RAM beat width. Multiple of 32.
- ADDR_BITWIDTH, RAM_DEPTH_BITWIDTH+$clog2(DATA_BITWIDTH/8): CPU byte address width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  cache can accept a request; high only in IDLE
- req_we  in  1  0: load, 1: store
- req_addr  in  ADDR_BITWIDTH  byte address; bits [1:0] ignored (word aligned)
- req_wstrb  in  4  store byte enables
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle response pulse, for loads and stores
- resp_rdata  out  32  load data; 0 for stores
- br_cmd  out  1  0: read, 1: write
- br_cmd_en  out  1  command strobe
- br_addr  out  RAM_DEPTH_BITWIDTH  line base word address (low $clog2(BURST_COUNT) bits = 0)
- br_wr_data  out  DATA_BITWIDTH  write beat
- br_data_mask  out  DATA_BITWIDTH/8  constant 0
- br_rd_data  in  DATA_BITWIDTH  read beat
- br_rd_data_valid  in  1  read beat valid
- br_busy  in  1  RAM busy

Behaviour:
- Address split:
  - word_sel = req_addr[1:0+...] is not used; the byte address splits as follows.
  - half_sel = the 32-bit lane within a beat.
  - beat_sel = the beat within the line.
  - tag = the remaining upper bits.
- Little-endian: byte address 0 maps to bits [7:0] of beat 0.
- Reset values:
  - state = IDLE, line_valid = 0, dirty = 0.
  - resp_valid = 0, resp_rdata = 0.
  - br_cmd_en = 0, br_cmd = 0, br_addr = 0, br_wr_data = 0.
  - Line data is not reset.
- State machine, one-hot, with states IDLE, WB, FILL, SERVE:
  - IDLE: req_ready = 1. On accept with hit (line_valid && tag match):
    - load: next cycle resp_valid = 1 with the selected word.
    - store: merge the enabled bytes into the line, set dirty; next cycle resp_valid = 1, resp_rdata = 0.
    - Stay in IDLE, so back-to-back hits run at 1 per cycle.
  - IDLE, accept with miss: latch the request. Go to WB if line_valid && dirty, else go to FILL.
  - WB:
    - Issue br_cmd_en = 1, br_cmd = 1, br_addr = old line base, br_wr_data = beat 0, in the first cycle with br_busy = 0.
    - Present beats 1..BURST_COUNT-1 on the following consecutive cycles.
    - Clear dirty, then go to FILL.
  - FILL:
    - Issue br_cmd_en = 1, br_cmd = 0, br_addr = new line base in the first cycle with br_busy = 0, excluding the cycle immediately after any cmd_en.
    - Capture br_rd_data into beat counter slot 0..BURST_COUNT-1 on each cycle with br_rd_data_valid = 1.
    - After the last beat: set tag, set line_valid = 1, go to SERVE.
  - SERVE: perform the latched access as a hit, pulse resp_valid next cycle, return to IDLE.
- br_cmd_en is high for exactly 1 cycle per burst. It is never asserted while br_busy = 1 or in the cycle after a previous br_cmd_en.
- Beat and address counters are $clog2(BURST_COUNT) bits wide. The line base is never incremented; beat offset wraps inside the line.
- A miss to a clean line performs no write burst.
- A store with wstrb = 0 on a hit still pulses resp_valid but leaves dirty unchanged.
- rd_data_valid beats arriving outside FILL are ignored.
- Reset mid-operation: return to IDLE, invalidate the line, discard the latched request, emit no response. The same rst also resets the RAM.

Decomposition:
- Shared package burst_ram_pkg holds:
  - the CMD_READ / CMD_WRITE constants;
  - the state encodings;
  - the line-geometry localparams (beat index width, tag width).
- Sub-module burst_line_store: BURST_COUNT x DATA_BITWIDTH register array with a 32-bit byte-enabled write port, a full-beat fill write port and a beat read port.

Test Plan:
- Cold load: RAM word 0 = 0x0123456789ABCDEF, load 0x00.
  - Expect one read burst at br_addr 0, no write burst.
  - Expect resp_rdata = 0x89ABCDEF the cycle after SERVE.
- Hit: load 0x04 next.
  - Expect resp_valid exactly 1 cycle after accept, rdata = 0x01234567, no br_cmd_en.
- Store merge: store 0x000000AA with wstrb = 0001 to 0x00, then load 0x00.
  - Expect rdata = 0x89ABCDAA, dirty = 1.
- Dirty eviction: load 0x20 (line 1).
  - Expect a write burst to base 0 with beat 0 = 0x0123456789ABCDAA, then a read burst at base 4.
  - Check RAM word 0 afterwards.
- Clean eviction: load 0x40 after the previous step, with the line clean.
  - Expect a read burst only.
- Reset mid-fill: assert rst during the READ_DELAY of a fill.
  - Expect no resp_valid, req_ready = 1 after reset.
  - The next load of the same address misses and refills.
